// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: IF/ID register layout and the canonical NOP.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    // Architectural widths; the IF/ID struct is sized from these.
    localparam int XLEN   = 32;
    localparam int ILEN   = 32;

    // addi x0, x0, 0 -- the canonical RV32I no-op used for bubbles.
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    // IF/ID pipeline register contents, shared with decode and the hazard unit.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [ILEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // Value the IF/ID register takes on reset and on a flush bubble.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc    = '0;
        b.pc4   = '0;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > stall (hold) > capture.
// Latency: 1 cycle from d to q.
// Backpressure: stall holds contents; flush inserts a NOP bubble even when stalled.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    // Pipeline register update with bubble on flush, hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= if_id_bubble();
        end else if (flush) begin
            // A taken branch squashes whatever is in fetch, stalled or not.
            q <= if_id_bubble();
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction-memory read address, feeds IF/ID.
// Latency: word at pc appears on if_id_instr one cycle after pc is presented.
// Backpressure: stall holds pc and IF/ID; flush redirects pc and bubbles IF/ID.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              INS_ADDRESS = 9,
    parameter int              DATA_W      = 32,
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [DATA_W-1:0]      imem_rd,
    output logic [PC_W-1:0]        if_id_pc,
    output logic [PC_W-1:0]        if_id_pc4,
    output logic [DATA_W-1:0]      if_id_instr,
    output logic                   if_id_valid,
    output logic [31:0]            fetch_cnt
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] redirect_aligned;
    logic            capture;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    // Redirect targets are word-aligned by dropping the low bits; misalignment never traps.
    assign redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};

    // The dropped low bits are intentionally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Sequential successor; wraps modulo 2^PC_W.
    assign pc_plus4 = pc + PC_W'(4);

    // Read address comes straight from the PC register so stall/flush never reach it
    // combinationally; addresses beyond the memory simply alias.
    assign imem_ra = pc[INS_ADDRESS-1:0];

    // A real instruction enters IF/ID only when neither squashed nor held.
    assign capture = !flush && !stall;

    // Next-PC select: flush redirects, stall holds, otherwise step by one word.
    always_comb begin
        pc_next = pc_plus4;
        if (flush) begin
            pc_next = redirect_aligned;
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Candidate IF/ID contents for this cycle's fetch.
    always_comb begin
        if_id_d       = if_id_bubble();
        if_id_d.pc    = pc;
        if_id_d.pc4   = pc_plus4;
        if_id_d.instr = imem_rd;
        if_id_d.valid = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .stall (stall),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign if_id_pc    = if_id_q.pc;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;

    // Count instructions actually captured into IF/ID; wraps at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
        end else if (capture) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule
